// File: rtl/tile_skew_buf.sv
`default_nettype none
// ============================================================================
// Module   : tile_skew_buf
// Brief    : Double-buffered DIMxDIM operand tile store streamed with a
//            per-lane diagonal skew in row order or transposed column order.
//            Optional macro CLEAR_ON_DONE_EN zeroes a bank once it has streamed.
// Revision : 1.0
// ============================================================================
module tile_skew_buf #(
    parameter int BITS = 8,
    parameter int DIM  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [$clog2(DIM)-1:0] wr_row,
    input  logic [DIM*BITS-1:0]    wr_data,
    input  logic                   wr_commit,
    output logic                   wr_ready,
    input  logic                   col_mode,
    input  logic                   start,
    output logic                   busy,
    output logic                   out_valid,
    output logic [DIM*BITS-1:0]    out_data,
    output logic                   done
);
    localparam int              C_AW       = $clog2(DIM);
    localparam int              C_TW       = $clog2(2*DIM-1);
    localparam logic [C_TW-1:0] C_T_LAST   = C_TW'(2*DIM-2);
    localparam logic [0:0]      C_S_IDLE   = 1'b0;
    localparam logic [0:0]      C_S_STREAM = 1'b1;

    logic [BITS-1:0]     r_mem [2][DIM][DIM];
    logic [1:0]          r_ready;
    logic                r_wb;
    logic                r_rb;
    logic                r_mode;
    logic [0:0]          r_state;
    logic [C_TW-1:0]     r_t;

    logic                w_wr_ok;
    logic                w_last;
    logic                w_accept;
    logic [1:0]          w_ready_nxt;
    logic [0:0]          w_state_nxt;
    logic [C_TW-1:0]     w_t_nxt;
    logic                w_mode_nxt;
    logic                w_rb_nxt;
    logic [DIM*BITS-1:0] w_data_nxt;

    assign w_wr_ok  = !r_ready[r_wb];
    assign wr_ready = w_wr_ok;
    assign w_last   = (r_state == C_S_STREAM) && (r_t == C_T_LAST);
    assign w_rb_nxt = w_last ? ~r_rb : r_rb;

    // Commit and done-clear always address different banks, so both may apply.
    always_comb begin
        w_ready_nxt = r_ready;
        if (wr_commit && w_wr_ok) w_ready_nxt[r_wb] = 1'b1;
        if (w_last)               w_ready_nxt[r_rb] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= '0;
            r_wb    <= 1'b0;
            r_rb    <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        r_mem[b][r][c] <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            if (w_last) begin
                r_rb <= ~r_rb;
`ifdef CLEAR_ON_DONE_EN
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        r_mem[r_rb][r][c] <= '0;
`endif
            end
            if (wr_en && w_wr_ok) begin
                for (int c = 0; c < DIM; c++)
                    r_mem[r_wb][wr_row][c] <= wr_data[c*BITS +: BITS];
            end
            if (wr_commit && w_wr_ok) r_wb <= ~r_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= C_S_IDLE;
            r_t       <= '0;
            r_mode    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_t       <= w_t_nxt;
            r_mode    <= w_mode_nxt;
            busy      <= (w_state_nxt == C_S_STREAM);
            out_valid <= (w_state_nxt == C_S_STREAM);
            done      <= (w_state_nxt == C_S_STREAM) && (w_t_nxt == C_T_LAST);
            out_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_mode_nxt  = r_mode;
        w_accept    = 1'b0;
        case (r_state)
            C_S_IDLE: begin
                if (start && r_ready[r_rb]) begin
                    w_accept    = 1'b1;
                    w_state_nxt = C_S_STREAM;
                    w_t_nxt     = '0;
                end
            end
            C_S_STREAM: begin
                if (w_last) begin
                    w_t_nxt = '0;
                    if (start && r_ready[~r_rb]) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = C_S_IDLE;
                    end
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            default: w_state_nxt = C_S_IDLE;
        endcase
        if (w_accept) w_mode_nxt = col_mode;
    end

    // Lane data is computed from the next state so out_data lines up with busy.
    generate
        for (genvar k = 0; k < DIM; k++) begin : g_lane
            logic [C_TW:0]   w_d;
            logic [BITS-1:0] w_val;
            assign w_d = {1'b0, w_t_nxt} - (C_TW+1)'(k);
            always_comb begin
                w_val = '0;
                if ((w_state_nxt == C_S_STREAM) && !w_d[C_TW] &&
                    (w_d[C_TW-1:0] < C_TW'(DIM))) begin
                    if (w_mode_nxt) w_val = r_mem[w_rb_nxt][w_d[C_AW-1:0]][C_AW'(k)];
                    else            w_val = r_mem[w_rb_nxt][C_AW'(k)][w_d[C_AW-1:0]];
                end
            end
            assign w_data_nxt[k*BITS +: BITS] = w_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tile_skew_buf.sv
`default_nettype none
// Bench for tile_skew_buf: directed and random tiles, outputs scored against
// a queue of expected stream cycles built from a tile-level model.
module tb_tile_skew_buf;
    localparam int BITS = 8;
    localparam int DIM  = 8;
    localparam int LAST = 2*DIM-2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr_en = 1'b0;
    logic [2:0]          wr_row = '0;
    logic [DIM*BITS-1:0] wr_data = '0;
    logic                wr_commit = 1'b0;
    logic                col_mode = 1'b0;
    logic                start = 1'b0;
    logic                wr_ready, busy, out_valid, done;
    logic [DIM*BITS-1:0] out_data;

    always #5 clk = ~clk;

    tile_skew_buf #(.BITS(BITS), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready), .col_mode(col_mode), .start(start),
        .busy(busy), .out_valid(out_valid), .out_data(out_data), .done(done)
    );

    typedef struct {
        logic [DIM*BITS-1:0] data;
        logic                done;
    } exp_t;

    exp_t           q[$];
    int             n_vec = 0;
    int             n_err = 0;
    logic [BITS-1:0] m_bank [2][DIM][DIM];
    bit             m_ready [2];
    int             m_wb, m_rb, m_t;
    bit             m_stream;
    bit             mon_en = 1'b0;
    int             run = 0;
    int             run_max = 0;
    int             order [8] = '{4, 5, 3, 0, 2, 1, 7, 6};
    logic [DIM*BITS-1:0] v;
    logic [7:0]     mask;
    int             n;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Expected lane k at stream cycle t is element (k, t-k) or (t-k, k).
    task automatic push_stream(int bank, bit mode);
        for (int t = 0; t <= LAST; t++) begin
            exp_t e;
            e.data = '0;
            for (int k = 0; k < DIM; k++) begin
                int i;
                i = t - k;
                if (i >= 0 && i < DIM)
                    e.data[k*BITS +: BITS] = mode ? m_bank[bank][i][k] : m_bank[bank][k][i];
            end
            e.done = (t == LAST);
            q.push_back(e);
        end
    endtask

    // Applies the current inputs to the model as the coming clock edge would.
    task automatic model_edge();
        bit ok, rb_rdy, other_rdy;
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++) m_bank[b][r][c] = '0;
            m_ready[0] = 0; m_ready[1] = 0;
            m_wb = 0; m_rb = 0; m_t = 0; m_stream = 0;
            q.delete();
            return;
        end
        ok        = !m_ready[m_wb];
        rb_rdy    = m_ready[m_rb];
        other_rdy = m_ready[1-m_rb];
        if (m_stream) begin
            if (m_t == LAST) begin
                m_ready[m_rb] = 0;
`ifdef CLEAR_ON_DONE_EN
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++) m_bank[m_rb][r][c] = '0;
`endif
                m_rb = 1 - m_rb;
                m_t  = 0;
                if (start && other_rdy) push_stream(m_rb, col_mode);
                else                    m_stream = 0;
            end else begin
                m_t++;
            end
        end else if (start && rb_rdy) begin
            push_stream(m_rb, col_mode);
            m_stream = 1;
            m_t = 0;
        end
        if (ok && wr_en)
            for (int c = 0; c < DIM; c++) m_bank[m_wb][wr_row][c] = wr_data[c*BITS +: BITS];
        if (ok && wr_commit) begin
            m_ready[m_wb] = 1;
            m_wb = 1 - m_wb;
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic write_row(int r, logic [DIM*BITS-1:0] d);
        wr_en = 1'b1; wr_row = 3'(r); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        step();
        wr_commit = 1'b0;
    endtask

    task automatic begin_stream(bit mode);
        col_mode = mode; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain(bit rnd_writes);
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            if (rnd_writes) begin
                wr_en   = 1'($urandom);
                wr_row  = 3'($urandom);
                wr_data = {$urandom, $urandom};
            end
            step();
            k++;
        end
        wr_en = 1'b0;
        check("drain_bound", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [DIM*BITS-1:0] tile_row(int r);
        logic [DIM*BITS-1:0] d;
        for (int c = 0; c < DIM; c++) d[c*BITS +: BITS] = 8'(16*r + c);
        return d;
    endfunction

    function automatic logic [DIM*BITS-1:0] rnd_row();
        return {$urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            n_vec++;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== e.data || done !== e.done) begin
                    n_err++;
                    $display("FAIL stream_cycle: valid=%b busy=%b data=%h done=%b, required valid=1 busy=1 data=%h done=%b",
                             out_valid, busy, out_data, done, e.data, e.done);
                end
            end else if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
                n_err++;
                $display("FAIL idle_outputs: valid=%b busy=%b data=%h done=%b, required all zero",
                         out_valid, busy, out_data, done);
            end
            if (out_valid === 1'b1) begin
                run++;
                if (run > run_max) run_max = run;
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        begin_stream(1'b0);
        check("start_no_commit_busy", 64'(busy), 64'd0);
        step();

        // Row-mode stream of tile[r][c] = 16r+c, rows written out of order.
        for (int i = 0; i < 8; i++) write_row(order[i], tile_row(order[i]));
        commit();
        begin_stream(1'b0);
        check("row_c0", out_data, 64'd0);
        repeat (7) step();
        for (int k = 0; k < DIM; k++) v[k*BITS +: BITS] = 8'(16*k + 7 - k);
        check("row_c7", out_data, v);
        repeat (7) step();
        check("row_c14_lane7", 64'(out_data[63:56]), 64'h77);
        check("row_c14_done", 64'(done), 64'd1);
        drain(1'b0);

        // Column mode, same tile in the other bank.
        for (int r = 0; r < 8; r++) write_row(r, tile_row(r));
        commit();
        begin_stream(1'b1);
        repeat (7) step();
        for (int k = 0; k < DIM; k++) v[k*BITS +: BITS] = 8'(16*(7-k) + k);
        check("col_c7", out_data, v);
        drain(1'b0);

        // Random tiles; later passes rewrite only some rows so stale or cleared rows show.
        for (int it = 0; it < 6; it++) begin
            mask = (it < 2) ? 8'hFF : (it < 4) ? 8'h01 : 8'($urandom);
            for (int r = 0; r < 8; r++) if (mask[r]) write_row(r, rnd_row());
            repeat ($urandom_range(0, 2)) step();
            commit();
            begin_stream(1'($urandom));
            drain(1'b1);
        end

        // Both banks full, then a back-to-back pair of streams.
        for (int r = 0; r < 8; r++) write_row(r, {8{8'h11}});
        commit();
        for (int r = 0; r < 8; r++) write_row(r, {8{8'h22}});
        commit();
        check("full_wr_ready", 64'(wr_ready), 64'd0);
        write_row(3, {8{8'h99}});
        commit();
        run_max = 0;
        begin_stream(1'($urandom));
        n = 0;
        while (!(m_stream && m_t == LAST) && n < 50) begin step(); n++; end
        check("b2b_done_seen", 64'(done), 64'd1);
        begin_stream(1'($urandom));
        drain(1'b0);
        check("b2b_contiguous", 64'(run_max), 64'd30);

        // Commit landing in the done cycle.
        for (int r = 0; r < 8; r++) write_row(r, rnd_row());
        commit();
        begin_stream(1'b0);
        for (int r = 0; r < 8; r++) write_row(r, rnd_row());
        n = 0;
        while (!(m_stream && m_t == LAST) && n < 50) begin step(); n++; end
        wr_commit = 1'b1;
        step();
        wr_commit = 1'b0;
        check("commit_done_wr_ready", 64'(wr_ready), 64'd1);
        begin_stream(1'b1);
        check("commit_done_restart", 64'(busy), 64'd1);
        drain(1'b0);

        // Reset in the middle of a stream, then a row-0-only reload.
        for (int r = 0; r < 8; r++) write_row(r, rnd_row());
        commit();
        begin_stream(1'b0);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", out_data, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_wr_ready", 64'(wr_ready), 64'd1);
        step();
        write_row(0, rnd_row());
        commit();
        begin_stream(1'($urandom));
        drain(1'b0);

        step(); step();
        check("final_queue", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
